// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, execute redirect and decode handshake.
// The fetch unit connects as master; the surrounding pipeline/memory connects as slave.
interface if_fetch_unit_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [31:0] id_pc_plus4;
   logic        misalign_err;

   modport master (
      output imem_addr, id_valid, id_pc, id_inst, id_pc_plus4, misalign_err,
      input  imem_inst, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_addr, id_valid, id_pc, id_inst, id_pc_plus4, misalign_err,
      output imem_inst, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, buffers fetched words with their PC in a
// small circular queue and hands them to decode; execute redirects flush everything.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input logic             clk,
   input logic             rst_n,
   if_fetch_unit_if.master bus
);
   localparam int unsigned      PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned      CNT_W    = $clog2(QDEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QDEPTH);

   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic             misalign_q, misalign_d;
   logic [31:0]      entry_pc_q [QDEPTH];
   logic [31:0]      entry_pc_d [QDEPTH];
   logic [31:0]      entry_inst_q [QDEPTH];
   logic [31:0]      entry_inst_d [QDEPTH];

   logic        id_valid, pop, push;
   logic [31:0] id_pc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path can infer a latch.
      pc_d         = pc_q;
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      entry_pc_d   = entry_pc_q;
      entry_inst_d = entry_inst_q;

      id_valid   = (count_q != '0);
      pop        = id_valid & bus.id_ready & ~bus.redirect_valid;
      push       = ~bus.redirect_valid & ((count_q < DEPTH_C) | pop);
      misalign_d = bus.redirect_valid & (|bus.redirect_pc[1:0]);

      if (bus.redirect_valid) begin
         // Flush: decode's handshake this cycle is void and nothing is fetched.
         pc_d     = {bus.redirect_pc[31:2], 2'b00};
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) begin
            entry_pc_d[wr_ptr_q]   = pc_q;
            entry_inst_d[wr_ptr_q] = bus.imem_inst;
            wr_ptr_d               = ptr_inc(wr_ptr_q);
            pc_d                   = pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         misalign_q <= misalign_d;
      end
   end

   // NOTE: queue storage is not reset; count_q gates every read, so stale contents are never seen.
   always_ff @(posedge clk) begin
      entry_pc_q   <= entry_pc_d;
      entry_inst_q <= entry_inst_d;
   end

   assign id_pc            = id_valid ? entry_pc_q[rd_ptr_q] : 32'h0000_0000;
   assign bus.imem_addr    = pc_q;
   assign bus.id_valid     = id_valid;
   assign bus.id_pc        = id_pc;
   assign bus.id_inst      = id_valid ? entry_inst_q[rd_ptr_q] : NOP_INST;
   assign bus.id_pc_plus4  = id_pc + 32'd4;
   assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic checked against a
// queue-based model of the fetch stage.
module tb_if_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          QDEPTH   = 2;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] inst_key;
   int          n_chk;
   int          n_fail;

   entry_t      m_q[$];
   logic [31:0] m_pc;
   logic        m_mis;

   if_fetch_unit_if bus ();

   if_fetch_unit #(
      .RESET_PC (RESET_PC),
      .QDEPTH   (QDEPTH),
      .NOP_INST (NOP_INST)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Instruction memory: word content is the address XOR a per-test key.
   assign bus.imem_inst = bus.imem_addr ^ inst_key;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic m_valid();
      return m_q.size() != 0;
   endfunction

   function automatic logic [31:0] m_id_pc();
      return (m_q.size() != 0) ? m_q[0].pc : 32'h0;
   endfunction

   function automatic logic [31:0] m_id_inst();
      return (m_q.size() != 0) ? m_q[0].inst : NOP_INST;
   endfunction

   task automatic set_in(input logic rst_v, input logic redir, input logic [31:0] rpc,
                         input logic rdy);
      @(negedge clk);
      rst_n              = rst_v;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      bus.id_ready       = rdy;
      #1;
   endtask

   // Clock edge plus the model's view of what that edge does.
   task automatic tick();
      int  sz;
      bit  pop, push;
      @(posedge clk);
      sz = m_q.size();
      if (!rst_n) begin
         m_q.delete();
         m_pc  = RESET_PC;
         m_mis = 1'b0;
      end else if (bus.redirect_valid) begin
         m_q.delete();
         m_pc  = bus.redirect_pc & 32'hFFFF_FFFC;
         m_mis = (bus.redirect_pc[1:0] != 2'b00);
      end else begin
         m_mis = 1'b0;
         pop   = (sz > 0) && bus.id_ready;
         push  = (sz < QDEPTH) || pop;
         if (pop) void'(m_q.pop_front());
         if (push) begin
            m_q.push_back('{pc: m_pc, inst: m_pc ^ inst_key});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic reset_dut();
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
   endtask

   task automatic test_reset();
      reset_dut();
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      n_chk++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset id_valid: got %b want 0", bus.id_valid); end
      n_chk++; if (bus.id_pc !== 32'h0) begin n_fail++; $display("FAIL reset id_pc: got %h want 0", bus.id_pc); end
      n_chk++; if (bus.id_inst !== NOP_INST) begin n_fail++; $display("FAIL reset id_inst: got %h want %h", bus.id_inst, NOP_INST); end
      n_chk++; if (bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset imem_addr: got %h want %h", bus.imem_addr, RESET_PC); end
      n_chk++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset misalign_err: got %b want 0", bus.misalign_err); end
      tick();
   endtask

   task automatic test_stream();
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 1'b0, 32'h0, 1'b1);
         n_chk++; if (bus.imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL stream imem_addr[%0d]: got %h want %h", i, bus.imem_addr, 4 * i); end
         n_chk++; if (bus.id_valid !== (i > 0)) begin n_fail++; $display("FAIL stream id_valid[%0d]: got %b want %b", i, bus.id_valid, i > 0); end
         if (i > 0) begin
            n_chk++; if (bus.id_pc !== 32'(4 * (i - 1))) begin n_fail++; $display("FAIL stream id_pc[%0d]: got %h want %h", i, bus.id_pc, 4 * (i - 1)); end
            n_chk++; if (bus.id_inst !== 32'(4 * (i - 1))) begin n_fail++; $display("FAIL stream id_inst[%0d]: got %h want %h", i, bus.id_inst, 4 * (i - 1)); end
            n_chk++; if (bus.id_pc_plus4 !== 32'(4 * i)) begin n_fail++; $display("FAIL stream id_pc_plus4[%0d]: got %h want %h", i, bus.id_pc_plus4, 4 * i); end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 1'b0, 32'h0, 1'b0);
         if (i > 0) begin
            n_chk++; if (bus.id_pc !== 32'h0) begin n_fail++; $display("FAIL stall id_pc hold[%0d]: got %h want 0", i, bus.id_pc); end
         end
         tick();
      end
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      n_chk++; if (bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall imem_addr: got %h want 8", bus.imem_addr); end
      n_chk++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL stall id_valid: got %b want 1", bus.id_valid); end
      tick();
      for (int j = 0; j < 4; j++) begin
         set_in(1'b1, 1'b0, 32'h0, 1'b1);
         n_chk++; if (bus.id_pc !== 32'(4 * j)) begin n_fail++; $display("FAIL drain id_pc[%0d]: got %h want %h", j, bus.id_pc, 4 * j); end
         n_chk++; if (bus.imem_addr !== 32'(8 + 4 * j)) begin n_fail++; $display("FAIL drain imem_addr[%0d]: got %h want %h", j, bus.imem_addr, 8 + 4 * j); end
         tick();
      end
   endtask

   task automatic test_redirect();
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, 32'h0, 1'b0);
         tick();
      end
      set_in(1'b1, 1'b1, 32'h0000_0100, 1'b1);
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      n_chk++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL redirect flush id_valid: got %b want 0", bus.id_valid); end
      n_chk++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL redirect imem_addr: got %h want 100", bus.imem_addr); end
      tick();
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, 1'b0, 32'h0, 1'b1);
         n_chk++; if (bus.id_pc !== 32'(32'h100 + 4 * k)) begin n_fail++; $display("FAIL redirect id_pc[%0d]: got %h want %h", k, bus.id_pc, 32'h100 + 4 * k); end
         tick();
      end
   endtask

   task automatic test_misalign();
      reset_dut();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      set_in(1'b1, 1'b1, 32'h0000_0102, 1'b1);
      n_chk++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign before: got %b want 0", bus.misalign_err); end
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      n_chk++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign pulse: got %b want 1", bus.misalign_err); end
      n_chk++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL misalign imem_addr: got %h want 100", bus.imem_addr); end
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      n_chk++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign width: got %b want 0", bus.misalign_err); end
      n_chk++; if (bus.id_pc !== 32'h100) begin n_fail++; $display("FAIL misalign id_pc: got %h want 100", bus.id_pc); end
      tick();
   endtask

   task automatic test_reset_mid();
      reset_dut();
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      set_in(1'b0, 1'b1, 32'h0000_0200, 1'b0);
      n_chk++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid queued id_valid: got %b want 1", bus.id_valid); end
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      n_chk++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid id_valid: got %b want 0", bus.id_valid); end
      n_chk++; if (bus.id_inst !== NOP_INST) begin n_fail++; $display("FAIL rstmid id_inst: got %h want %h", bus.id_inst, NOP_INST); end
      n_chk++; if (bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rstmid imem_addr: got %h want %h", bus.imem_addr, RESET_PC); end
      tick();
      for (int i = 1; i < 4; i++) begin
         set_in(1'b1, 1'b0, 32'h0, 1'b1);
         n_chk++; if (bus.id_pc !== 32'(4 * (i - 1))) begin n_fail++; $display("FAIL rstmid resume id_pc[%0d]: got %h want %h", i, bus.id_pc, 4 * (i - 1)); end
         tick();
      end
   endtask

   task automatic test_wrap();
      reset_dut();
      set_in(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      n_chk++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap imem_addr: got %h want fffffffc", bus.imem_addr); end
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      n_chk++; if (bus.id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap id_pc first: got %h want fffffffc", bus.id_pc); end
      n_chk++; if (bus.id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap id_pc_plus4: got %h want 0", bus.id_pc_plus4); end
      n_chk++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap pc rollover: got %h want 0", bus.imem_addr); end
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      n_chk++; if (bus.id_pc !== 32'h0) begin n_fail++; $display("FAIL wrap id_pc second: got %h want 0", bus.id_pc); end
      tick();
   endtask

   task automatic test_random();
      logic        r_rst, r_redir, r_rdy;
      logic [31:0] r_pc;
      inst_key = $urandom;
      reset_dut();
      for (int c = 0; c < 600; c++) begin
         r_rst   = ($urandom_range(0, 59) != 0);
         r_redir = ($urandom_range(0, 9) == 0);
         r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         r_rdy   = ($urandom_range(0, 3) != 0);
         set_in(r_rst, r_redir, r_pc, r_rdy);
         n_chk++; if (bus.imem_addr !== m_pc) begin n_fail++; $display("FAIL rand imem_addr c=%0d: got %h want %h", c, bus.imem_addr, m_pc); end
         n_chk++; if (bus.id_valid !== m_valid()) begin n_fail++; $display("FAIL rand id_valid c=%0d: got %b want %b", c, bus.id_valid, m_valid()); end
         n_chk++; if (bus.id_pc !== m_id_pc()) begin n_fail++; $display("FAIL rand id_pc c=%0d: got %h want %h", c, bus.id_pc, m_id_pc()); end
         n_chk++; if (bus.id_inst !== m_id_inst()) begin n_fail++; $display("FAIL rand id_inst c=%0d: got %h want %h", c, bus.id_inst, m_id_inst()); end
         n_chk++; if (bus.id_pc_plus4 !== m_id_pc() + 32'd4) begin n_fail++; $display("FAIL rand id_pc_plus4 c=%0d: got %h want %h", c, bus.id_pc_plus4, m_id_pc() + 32'd4); end
         n_chk++; if (bus.misalign_err !== m_mis) begin n_fail++; $display("FAIL rand misalign_err c=%0d: got %b want %b", c, bus.misalign_err, m_mis); end
         tick();
      end
   endtask

   initial begin
      n_chk              = 0;
      n_fail             = 0;
      inst_key           = 32'h0;
      m_pc               = RESET_PC;
      m_mis              = 1'b0;
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.id_ready       = 1'b0;

      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_misalign();
      test_reset_mid();
      test_wrap();
      test_random();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
